wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-bank write-port arbiter: EX results take priority, load responses are
// buffered in a small FIFO (or bypassed when idle), and a busy scoreboard flags load-use hazards.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_valid_i,
  input  logic [ADDR_WIDTH-1:0]         ex_addr_i,
  input  logic [WORD_WIDTH-1:0]         ex_data_i,
  input  logic                          lsu_valid_i,
  output logic                          lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]         lsu_addr_i,
  input  logic [WORD_WIDTH-1:0]         lsu_data_i,
  input  logic                          issue_load_i,
  input  logic [ADDR_WIDTH-1:0]         issue_addr_i,
  input  logic [ADDR_WIDTH-1:0]         chk_addr1_i,
  input  logic [ADDR_WIDTH-1:0]         chk_addr2_i,
  output logic                          hazard_o,
  output logic                          write_en_o,
  output logic [ADDR_WIDTH-1:0]         write_addr_o,
  output logic [WORD_WIDTH-1:0]         write_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [NREG-1:0]       busy, busy_next;

  logic                  push_hs;
  logic                  do_push, do_pop;
  logic                  sel_valid, sel_load;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WORD_WIDTH-1:0] sel_data;

  // Handshake: a load response transfers on any rising edge where lsu_valid_i && lsu_ready_o.
  // ready depends only on registered occupancy (and reset), never on lsu_valid_i.
  assign lsu_ready_o  = (count < FULL) && !rst;
  assign push_hs      = lsu_valid_i && lsu_ready_o;
  assign fifo_count_o = count;
  assign hazard_o     = busy[chk_addr1_i] | busy[chk_addr2_i];

  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_addr  = ex_addr_i;
    sel_data  = ex_data_i;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    if (ex_valid_i) begin
      sel_valid = 1'b1;
      do_push   = push_hs;
    end else if (count != '0) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_addr  = fifo_addr[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
      do_pop    = 1'b1;
      do_push   = push_hs;
    end else if (push_hs) begin
      // Idle port and empty buffer: the load goes straight to the output registers.
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_addr  = lsu_addr_i;
      sel_data  = lsu_data_i;
    end
  end

  always_comb begin
    busy_next = busy;
    if (sel_load) busy_next[sel_addr] = 1'b0;
    // A new issue to the same register wins over the retiring load.
    if (issue_load_i && (issue_addr_i != '0)) busy_next[issue_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_addr[wr_ptr] <= lsu_addr_i;
      fifo_data[wr_ptr] <= lsu_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Entries addressed to x0 are consumed silently; address/data hold their last written value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
    end else begin
      write_en_o <= sel_valid && (sel_addr != '0);
      if (sel_valid && (sel_addr != '0)) begin
        write_addr_o <= sel_addr;
        write_data_o <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int WW = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_valid_i;
  logic [AW-1:0] ex_addr_i;
  logic [WW-1:0] ex_data_i;
  logic          lsu_valid_i;
  logic          lsu_ready_o;
  logic [AW-1:0] lsu_addr_i;
  logic [WW-1:0] lsu_data_i;
  logic          issue_load_i;
  logic [AW-1:0] issue_addr_i;
  logic [AW-1:0] chk_addr1_i;
  logic [AW-1:0] chk_addr2_i;
  logic          hazard_o;
  logic          write_en_o;
  logic [AW-1:0] write_addr_o;
  logic [WW-1:0] write_data_o;
  logic [1:0]    fifo_count_o;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .issue_load_i(issue_load_i), .issue_addr_i(issue_addr_i),
    .chk_addr1_i(chk_addr1_i), .chk_addr2_i(chk_addr2_i),
    .hazard_o(hazard_o), .write_en_o(write_en_o),
    .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .fifo_count_o(fifo_count_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW+WW-1:0] exp_q[$];
  logic [31:0]      m_busy = '0;
  logic             m_we   = 1'b0;
  logic [AW-1:0]    m_wa   = '0;
  logic [WW-1:0]    m_wd   = '0;
  logic             m_hs, m_sv, m_sl;
  logic [AW-1:0]    m_sa;
  logic [WW-1:0]    m_sd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_busy = '0;
      m_we   = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
    end else begin
      m_hs = lsu_valid_i && (exp_q.size() < D);
      m_sv = 1'b0;
      m_sl = 1'b0;
      m_sa = '0;
      m_sd = '0;
      if (ex_valid_i) begin
        m_sv = 1'b1;
        m_sa = ex_addr_i;
        m_sd = ex_data_i;
      end else if (exp_q.size() > 0) begin
        m_sv = 1'b1;
        m_sl = 1'b1;
        {m_sa, m_sd} = exp_q.pop_front();
      end else if (m_hs) begin
        m_sv = 1'b1;
        m_sl = 1'b1;
        m_sa = lsu_addr_i;
        m_sd = lsu_data_i;
        m_hs = 1'b0;
      end
      if (m_hs) exp_q.push_back({lsu_addr_i, lsu_data_i});
      if (m_sl) m_busy[m_sa] = 1'b0;
      if (issue_load_i && issue_addr_i != '0) m_busy[issue_addr_i] = 1'b1;
      m_we = m_sv && (m_sa != '0);
      if (m_we) begin
        m_wa = m_sa;
        m_wd = m_sd;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("m_write_en", write_en_o, m_we);
    chk("m_write_addr", write_addr_o, m_wa);
    chk("m_write_data", write_data_o, m_wd);
    chk("m_fifo_count", fifo_count_o, exp_q.size());
    chk("m_lsu_ready", lsu_ready_o, (!rst && exp_q.size() < D));
    chk("m_hazard", hazard_o, m_busy[chk_addr1_i] | m_busy[chk_addr2_i]);
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    ex_valid_i   = 1'b0; ex_addr_i  = '0; ex_data_i  = '0;
    lsu_valid_i  = 1'b0; lsu_addr_i = '0; lsu_data_i = '0;
    issue_load_i = 1'b0; issue_addr_i = '0;
    chk_addr1_i  = '0;   chk_addr2_i  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ex(input logic v, input logic [AW-1:0] a, input logic [WW-1:0] d);
    ex_valid_i = v; ex_addr_i = a; ex_data_i = d;
  endtask

  task automatic ld(input logic v, input logic [AW-1:0] a, input logic [WW-1:0] d);
    lsu_valid_i = v; lsu_addr_i = a; lsu_data_i = d;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    idle();
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_we", write_en_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_ready", lsu_ready_o, 0);
    chk("rst_hazard", hazard_o, 0);
    rst = 1'b0;
    #1 chk("rel_ready", lsu_ready_o, 1);

    // EX only
    ex(1, 3, 32'hDEADBEEF);
    tick();
    chk("ex_we", write_en_o, 1);
    chk("ex_addr", write_addr_o, 3);
    chk("ex_data", write_data_o, 32'hDEADBEEF);
    idle();
    tick();
    chk("ex_we_low", write_en_o, 0);
    chk("ex_addr_hold", write_addr_o, 3);

    // bypass
    ld(1, 7, 32'h11);
    tick();
    chk("byp_we", write_en_o, 1);
    chk("byp_addr", write_addr_o, 7);
    chk("byp_data", write_data_o, 32'h11);
    chk("byp_count", fifo_count_o, 0);
    idle();

    // conflict: EX streams while loads buffer
    ex(1, 1, 32'h100); ld(1, 5, 32'hA);
    tick();
    chk("cf_count1", fifo_count_o, 1);
    chk("cf_ex1", write_addr_o, 1);
    ex(1, 2, 32'h200); ld(1, 6, 32'hB);
    tick();
    chk("cf_count2", fifo_count_o, 2);
    chk("cf_ready_full", lsu_ready_o, 0);
    ex(1, 3, 32'h300); ld(0, 0, 0);
    tick();
    chk("cf_count_hold", fifo_count_o, 2);
    idle();
    tick();
    chk("cf_we5", write_en_o, 1);
    chk("cf_addr5", write_addr_o, 5);
    chk("cf_data5", write_data_o, 32'hA);
    chk("cf_count_pop", fifo_count_o, 1);
    tick();
    chk("cf_addr6", write_addr_o, 6);
    chk("cf_data6", write_data_o, 32'hB);
    chk("cf_count0", fifo_count_o, 0);
    tick();
    chk("cf_done", write_en_o, 0);

    // scoreboard
    issue_load_i = 1; issue_addr_i = 9; chk_addr1_i = 9;
    tick();
    chk("sb_haz1", hazard_o, 1);
    issue_load_i = 0;
    tick();
    chk("sb_haz2", hazard_o, 1);
    ld(1, 9, 32'h99); issue_load_i = 1; issue_addr_i = 9;
    tick();
    chk("sb_we9", write_addr_o, 9);
    chk("sb_set_wins", hazard_o, 1);
    ld(1, 9, 32'h98); issue_load_i = 0;
    tick();
    chk("sb_data98", write_data_o, 32'h98);
    chk("sb_cleared", hazard_o, 0);

    // x0 handling
    idle();
    issue_load_i = 1; issue_addr_i = 0; ld(1, 0, 32'h55);
    tick();
    chk("x0_we", write_en_o, 0);
    chk("x0_haz", hazard_o, 0);
    chk("x0_addr_hold", write_addr_o, 9);
    chk("x0_data_hold", write_data_o, 32'h98);
    idle();
    tick();

    // reset mid-operation
    issue_load_i = 1; issue_addr_i = 4; chk_addr1_i = 4;
    ex(1, 1, 32'h1); ld(1, 10, 32'h10);
    tick();
    issue_load_i = 0;
    ex(1, 2, 32'h2); ld(1, 11, 32'h11);
    tick();
    chk("mr_count2", fifo_count_o, 2);
    chk("mr_haz", hazard_o, 1);
    rst = 1'b1;
    #1;
    chk("mr_we", write_en_o, 0);
    chk("mr_addr", write_addr_o, 0);
    chk("mr_data", write_data_o, 0);
    chk("mr_count", fifo_count_o, 0);
    chk("mr_ready", lsu_ready_o, 0);
    chk("mr_hazard", hazard_o, 0);
    tick();
    rst = 1'b0;
    idle();
    chk_addr1_i = 4;
    tick();
    tick();
    chk("mr_no_stale", write_en_o, 0);
    chk("mr_haz_after", hazard_o, 0);
    chk("mr_count_after", fifo_count_o, 0);
    chk("mr_ready_after", lsu_ready_o, 1);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 80; i++) begin
      ex($urandom_range(0, 3) == 0, AW'($urandom_range(0, 31)), $urandom);
      ld($urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom);
      issue_load_i = ($urandom_range(0, 2) == 0);
      issue_addr_i = AW'($urandom_range(0, 31));
      chk_addr1_i  = AW'($urandom_range(0, 31));
      chk_addr2_i  = AW'($urandom_range(0, 31));
      tick();
    end
    idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
